// File: rtl/ir_fetch_queue.sv
// Instruction register fronted by a small prefetch FIFO. An empty FIFO is
// bypassed so a lone fetched word reaches IR after one edge.
module ir_fetch_queue #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [WIDTH-1:0]           MRD,
   input  logic                       MVALID,
   output logic                       MREADY,
   input  logic                       EN,
   input  logic                       FLUSH,
   output logic [WIDTH-1:0]           IR,
   output logic                       IR_VALID,
   output logic [$clog2(DEPTH):0]     COUNT
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] ir_reg, ir_next;
   logic             ir_valid_reg, ir_valid_next;
   logic             push, ld, mem_we;

   // Full blocks pushes outright, even when a pop frees a slot this cycle.
   assign MREADY = (count_reg < CW'(DEPTH));
   assign push   = MVALID & MREADY;
   assign ld     = EN | ~ir_valid_reg;

   always_comb begin
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      count_next    = count_reg;
      ir_next       = ir_reg;
      ir_valid_next = ir_valid_reg;
      mem_we        = 1'b0;
      if (FLUSH) begin
         rd_ptr_next   = '0;
         wr_ptr_next   = '0;
         count_next    = '0;
         ir_valid_next = 1'b0;
      end else if (ld) begin
         if (count_reg != '0) begin
            ir_next       = mem[rd_ptr_reg];
            ir_valid_next = 1'b1;
            rd_ptr_next   = rd_ptr_reg + PW'(1);
            if (push) begin
               mem_we      = 1'b1;
               wr_ptr_next = wr_ptr_reg + PW'(1);
            end else begin
               count_next  = count_reg - CW'(1);
            end
         end else if (push) begin
            // Bypass: the FIFO is empty so the word goes straight to IR.
            ir_next       = MRD;
            ir_valid_next = 1'b1;
         end else begin
            ir_valid_next = 1'b0;
         end
      end else if (push) begin
         mem_we      = 1'b1;
         wr_ptr_next = wr_ptr_reg + PW'(1);
         count_next  = count_reg + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) mem[wr_ptr_reg] <= MRD;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         ir_reg       <= RESET_VAL;
         ir_valid_reg <= 1'b0;
      end else begin
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
         ir_reg       <= ir_next;
         ir_valid_reg <= ir_valid_next;
      end
   end

   assign IR       = ir_reg;
   assign IR_VALID = ir_valid_reg;
   assign COUNT    = count_reg;

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Bench for ir_fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ir_fetch_queue;

   localparam int          WIDTH     = 32;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_VAL = 32'h0;

   logic                   CLK = 1'b0;
   logic                   RST_N = 1'b0;
   logic [WIDTH-1:0]       MRD = '0;
   logic                   MVALID = 1'b0;
   logic                   MREADY;
   logic                   EN = 1'b0;
   logic                   FLUSH = 1'b0;
   logic [WIDTH-1:0]       IR;
   logic                   IR_VALID;
   logic [$clog2(DEPTH):0] COUNT;

   int checks = 0;
   int failures = 0;

   ir_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
      .CLK(CLK), .RST_N(RST_N), .MRD(MRD), .MVALID(MVALID), .MREADY(MREADY),
      .EN(EN), .FLUSH(FLUSH), .IR(IR), .IR_VALID(IR_VALID), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   // Reference model: the pending words are a plain queue; IR is the word
   // most recently handed to decode.
   logic [31:0] q[$];
   logic [31:0] m_ir = RESET_VAL;
   logic        m_valid = 1'b0;

   always @(posedge CLK or negedge RST_N) begin
      bit accepted;
      if (!RST_N) begin
         q.delete();
         m_ir    = RESET_VAL;
         m_valid = 1'b0;
      end else begin
         accepted = MVALID && (q.size() < DEPTH);
         if (FLUSH) begin
            q.delete();
            m_valid = 1'b0;
         end else if (EN || !m_valid) begin
            if (accepted) q.push_back(MRD);
            if (q.size() > 0) begin
               m_ir    = q.pop_front();
               m_valid = 1'b1;
            end else begin
               m_valid = 1'b0;
            end
         end else if (accepted) begin
            q.push_back(MRD);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge CLK) begin
      chk("model_ir", IR, m_ir);
      chk("model_ir_valid", 32'(IR_VALID), 32'(m_valid));
      chk("model_count", 32'(COUNT), 32'(q.size()));
      chk("model_mready", 32'(MREADY), 32'(q.size() < DEPTH));
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   logic [31:0] seq[9];
   logic [31:0] held_ir;

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_ir", IR, RESET_VAL);
      chk("rst_valid", 32'(IR_VALID), 32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_mready", 32'(MREADY), 32'd1);
      RST_N = 1'b1;
      tick();

      // Bypass into empty queue
      MRD = 32'h8C010004; MVALID = 1'b1; EN = 1'b0;
      tick();
      MVALID = 1'b0;
      $display("bypass: IR=%h valid=%0d count=%0d", IR, IR_VALID, COUNT);
      chk("byp_ir", IR, 32'h8C010004);
      chk("byp_valid", 32'(IR_VALID), 32'd1);
      chk("byp_count", 32'(COUNT), 32'd0);

      // Fill to full, then a rejected fifth word
      for (int i = 1; i <= 4; i++) begin
         MRD = 32'hA0 + 32'(i); MVALID = 1'b1;
         tick();
         $display("fill: push %h count=%0d", MRD, COUNT);
      end
      chk("full_count", 32'(COUNT), 32'd4);
      chk("full_mready", 32'(MREADY), 32'd0);
      MRD = 32'hA5;
      tick();
      MVALID = 1'b0;
      chk("full_reject_count", 32'(COUNT), 32'd4);

      // Drain in order
      EN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         $display("drain: IR=%h count=%0d", IR, COUNT);
         chk("drain_ir", IR, 32'hA1 + 32'(i));
         chk("drain_count", 32'(COUNT), 32'(3 - i));
      end
      tick();
      chk("drain_empty_valid", 32'(IR_VALID), 32'd0);
      chk("drain_empty_ir", IR, 32'hA4);
      EN = 1'b0;

      // COUNT=2 then push+pop every cycle across pointer wrap
      seq[0] = 32'hD0; seq[1] = 32'hD1; seq[2] = 32'hD2;
      for (int i = 0; i < 6; i++) seq[3+i] = 32'hC0 + 32'(i);
      for (int i = 0; i < 3; i++) begin
         MRD = seq[i]; MVALID = 1'b1;
         tick();
      end
      chk("pp_pre_count", 32'(COUNT), 32'd2);
      chk("pp_pre_ir", IR, 32'hD0);
      EN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         MRD = seq[3+k];
         tick();
         $display("pushpop: push %h IR=%h count=%0d", seq[3+k], IR, COUNT);
         chk("pp_ir", IR, seq[k+1]);
         chk("pp_count", 32'(COUNT), 32'd2);
         chk("pp_mready", 32'(MREADY), 32'd1);
      end
      held_ir = seq[6];
      EN = 1'b0;

      // Bring COUNT to 3, then flush with a concurrent push and EN
      MRD = 32'hE0; MVALID = 1'b1;
      tick();
      chk("pre_flush_count", 32'(COUNT), 32'd3);
      FLUSH = 1'b1; EN = 1'b1; MRD = 32'hBB; MVALID = 1'b1;
      tick();
      FLUSH = 1'b0; EN = 1'b0;
      $display("flush: IR=%h valid=%0d count=%0d", IR, IR_VALID, COUNT);
      chk("flush_count", 32'(COUNT), 32'd0);
      chk("flush_valid", 32'(IR_VALID), 32'd0);
      chk("flush_mready", 32'(MREADY), 32'd1);
      chk("flush_ir_held", IR, held_ir);
      MRD = 32'hCC;
      tick();
      MVALID = 1'b0;
      chk("post_flush_ir", IR, 32'hCC);
      chk("post_flush_valid", 32'(IR_VALID), 32'd1);

      // Asynchronous reset in the middle of a cycle
      for (int i = 0; i < 3; i++) begin
         MRD = 32'hF0 + 32'(i); MVALID = 1'b1;
         tick();
      end
      MVALID = 1'b0;
      chk("pre_rst_count", 32'(COUNT), 32'd3);
      #2 RST_N = 1'b0;
      #1;
      $display("async reset: IR=%h valid=%0d count=%0d", IR, IR_VALID, COUNT);
      chk("arst_ir", IR, RESET_VAL);
      chk("arst_valid", 32'(IR_VALID), 32'd0);
      chk("arst_count", 32'(COUNT), 32'd0);
      chk("arst_mready", 32'(MREADY), 32'd1);
      tick();
      RST_N = 1'b1;
      MRD = 32'h12345678; MVALID = 1'b1;
      tick();
      MVALID = 1'b0;
      chk("arst_bypass_ir", IR, 32'h12345678);
      chk("arst_bypass_count", 32'(COUNT), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         MRD    = $urandom;
         MVALID = ($urandom_range(0, 99) < 60);
         EN     = ($urandom_range(0, 99) < 45);
         FLUSH  = ($urandom_range(0, 99) < 4);
         tick();
      end
      MVALID = 1'b0; EN = 1'b0; FLUSH = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ir_fetch_queue.md
Name: ir_fetch_queue

Overview:
- Parametrised instruction register with a prefetch FIFO, sitting between instruction memory read data and the decode/control FSM of the multicycle core.
- Memory pushes fetched words with a valid/ready handshake; decode consumes the current instruction by pulsing EN.
- An empty queue is bypassed straight into IR, so single-word latency matches a plain instruction register.
- FLUSH discards all prefetched words on a branch or jump redirect.

Parameters:
- WIDTH, 32, instruction word width in bits.
- DEPTH, 4, number of FIFO entries, excluding IR; power of two, at least 2.
- RESET_VAL, 0, value IR takes on reset (NOP encoding).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- MRD  input  WIDTH  memory read data (fetched instruction).
- MVALID  input  1  MRD valid this cycle.
- MREADY  output  1  queue can accept a word this cycle.
- EN  input  1  decode consumes the current IR and requests the next.
- FLUSH  input  1  synchronous discard of queue contents and IR validity.
- IR  output  WIDTH  current instruction (registered).
- IR_VALID  output  1  IR holds an unconsumed instruction.
- COUNT  output  $clog2(DEPTH)+1  number of words held in the FIFO, excluding IR.

Behaviour:
- Reset: asynchronous, active-low. While RST_N=0:
  - IR=RESET_VAL, IR_VALID=0, COUNT=0.
  - Read and write pointers = 0.
  - MREADY=1.
- MREADY = (COUNT < DEPTH), combinational from COUNT only.
  - No push when full, even if a pop happens in the same cycle.
- push = MVALID & MREADY. ld = EN | ~IR_VALID.
  - EN while IR_VALID=0 is harmless; it is equivalent to ld.
- Priority per rising edge: FLUSH, then load, then push.
- FLUSH=1:
  - COUNT<=0, pointers<=0, IR_VALID<=0, IR keeps its old value.
  - A word pushed in the same cycle is discarded; the source treats it as accepted.
  - EN in the same cycle is ignored.
- FLUSH=0 and ld=1:
  - COUNT>0: IR<=FIFO head, IR_VALID<=1, read pointer increments.
    - A concurrent push writes the tail, so COUNT stays unchanged on push+pop.
  - COUNT=0 and push: bypass. IR<=MRD, IR_VALID<=1, FIFO not written, COUNT stays 0.
  - COUNT=0 and no push: IR_VALID<=0, IR keeps its old value.
- FLUSH=0 and ld=0:
  - push writes the tail, write pointer increments, COUNT+1.
  - IR and IR_VALID are unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. COUNT never exceeds DEPTH and never underflows.
- Order is strict FIFO. IR always presents the oldest unconsumed word.
- Latency:
  - Word pushed into an empty queue while ld=1 appears on IR after 1 edge.
  - Otherwise it appears 1 edge after all older words have been consumed.
- IR is a stable register output; it changes only on a load or on reset.

Test Plan:
1. Async reset mid-operation: COUNT=3, IR_VALID=1; drop RST_N between edges -> immediately IR=RESET_VAL, IR_VALID=0, COUNT=0, MREADY=1; after release, the first push bypasses correctly.
2. Bypass: empty queue, IR_VALID=0, MVALID=1, MRD=32'h8C010004 -> after 1 edge IR=32'h8C010004, IR_VALID=1, COUNT=0.
3. Fill and backpressure: IR_VALID=1, EN=0, push 32'hA1..32'hA4 -> COUNT=4, MREADY=0; a 5th MVALID with 32'hA5 is not accepted and COUNT stays 4.
4. Drain order: continue from 3 with EN=1 each cycle and no push:
   - IR sequence is 32'hA1, 32'hA2, 32'hA3, 32'hA4, one per edge.
   - COUNT goes 3, 2, 1, 0.
   - Next EN gives IR_VALID=0 with IR held at 32'hA4.
5. Simultaneous push and pop with wrap: COUNT=2, EN=1 and push every cycle for 6 cycles -> COUNT stays 2, IR sequence preserves push order across pointer wrap, MREADY stays 1.
6. Flush: COUNT=3, IR_VALID=1, FLUSH=1 with MVALID=1, MRD=32'hBB, EN=1:
   - Next cycle COUNT=0, IR_VALID=0, MREADY=1, IR unchanged.
   - 32'hBB never appears on IR.
   - The following push of 32'hCC bypasses into IR after 1 edge.
